jtag_axis_sequencer: RTL and testbench



---
 rtl/jtag_axis_sequencer.sv | 138 +++++++++++++
 tb/tb_jtag_axis_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_axis_sequencer.sv
// Command front-end for the 32-bit JTAG shift engine.
// Accepts TMS/TDI word pairs on an AXI4-Stream slave and loads them into the engine.
// Starts the engine with a one-cycle ENABLE pulse, then waits for DONE.
// Returns the captured TDO word on an AXI4-Stream master, keeping packet
// boundaries intact. A DONE timeout and a misplaced TLAST are recorded as
// sticky error flags.
module jtag_axis_sequencer #(
    parameter int C_DONE_TIMEOUT  = 4096,
    parameter int C_TIMEOUT_WIDTH = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] S_AXIS_TDATA,
    input  logic        S_AXIS_TVALID,
    output logic        S_AXIS_TREADY,
    input  logic        S_AXIS_TLAST,
    output logic [31:0] M_AXIS_TDATA,
    output logic        M_AXIS_TVALID,
    input  logic        M_AXIS_TREADY,
    output logic        M_AXIS_TLAST,
    output logic        JTAG_ENABLE,
    input  logic        JTAG_DONE,
    output logic [31:0] JTAG_TMS_VECTOR,
    output logic [31:0] JTAG_TDI_VECTOR,
    input  logic [31:0] JTAG_TDO_VECTOR,
    output logic        BUSY,
    output logic [31:0] PAIR_COUNT,
    output logic        TIMEOUT_ERR,
    output logic        PROTO_ERR
);

    typedef enum logic [2:0] {
        GET_TMS,
        GET_TDI,
        START,
        WAIT_DONE,
        SEND_TDO
    } state_t;

    // Last count value of WAIT_DONE before the pair is abandoned.
    localparam logic [C_TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = C_TIMEOUT_WIDTH'(C_DONE_TIMEOUT - 1);

    state_t                     state;
    logic [C_TIMEOUT_WIDTH-1:0] timeout_cnt;
    logic                       tlast_latch;
    logic                       s_hs;
    logic                       m_hs;

    assign s_hs = S_AXIS_TVALID & S_AXIS_TREADY;
    assign m_hs = M_AXIS_TVALID & M_AXIS_TREADY;
    assign BUSY = (state != GET_TMS);

    // Pair sequencing FSM; every output except BUSY is a register updated here.
    always_ff @(posedge CLK) begin
        // NOTE: every register in this block, datapath included, is
        // cleared by the synchronous reset, so a reset mid-pair leaves no stale
        // vector or TDO word behind.
        if (RESET) begin
            state           <= GET_TMS;
            S_AXIS_TREADY   <= 1'b0;
            M_AXIS_TDATA    <= '0;
            M_AXIS_TVALID   <= 1'b0;
            M_AXIS_TLAST    <= 1'b0;
            JTAG_ENABLE     <= 1'b0;
            JTAG_TMS_VECTOR <= '0;
            JTAG_TDI_VECTOR <= '0;
            PAIR_COUNT      <= '0;
            TIMEOUT_ERR     <= 1'b0;
            PROTO_ERR       <= 1'b0;
            tlast_latch     <= 1'b0;
            timeout_cnt     <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch
            // sees the register values from before this edge.
            case (state)
                GET_TMS: begin
                    S_AXIS_TREADY <= 1'b1;
                    if (s_hs) begin
                        JTAG_TMS_VECTOR <= S_AXIS_TDATA;
                        if (S_AXIS_TLAST) begin
                            // TLAST on a TMS word: drop the word, wait for a fresh TMS.
                            PROTO_ERR <= 1'b1;
                        end else begin
                            state <= GET_TDI;
                        end
                    end
                end

                GET_TDI: begin
                    if (s_hs) begin
                        JTAG_TDI_VECTOR <= S_AXIS_TDATA;
                        tlast_latch     <= S_AXIS_TLAST;
                        S_AXIS_TREADY   <= 1'b0;
                        JTAG_ENABLE     <= 1'b1;
                        state           <= START;
                    end
                end

                START: begin
                    JTAG_ENABLE <= 1'b0;
                    timeout_cnt <= '0;
                    state       <= WAIT_DONE;
                end

                WAIT_DONE: begin
                    timeout_cnt <= timeout_cnt + C_TIMEOUT_WIDTH'(1);
                    // DONE is tested first so it wins over a coinciding timeout.
                    if (JTAG_DONE) begin
                        M_AXIS_TDATA  <= JTAG_TDO_VECTOR;
                        M_AXIS_TLAST  <= tlast_latch;
                        M_AXIS_TVALID <= 1'b1;
                        state         <= SEND_TDO;
                    end else if (timeout_cnt == TIMEOUT_LAST) begin
                        TIMEOUT_ERR   <= 1'b1;
                        M_AXIS_TDATA  <= 32'hFFFF_FFFF;
                        M_AXIS_TLAST  <= tlast_latch;
                        M_AXIS_TVALID <= 1'b1;
                        state         <= SEND_TDO;
                    end
                end

                SEND_TDO: begin
                    if (m_hs) begin
                        M_AXIS_TVALID <= 1'b0;
                        PAIR_COUNT    <= PAIR_COUNT + 32'd1;
                        S_AXIS_TREADY <= 1'b1;
                        state         <= GET_TMS;
                    end
                end

                default: begin
                    state <= GET_TMS;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_axis_sequencer.sv
// Self-checking bench for jtag_axis_sequencer.
// A loopback shift-engine model returns the TDI word as TDO after a
// programmable delay, or never answers at all. A pair-level scoreboard
// predicts each output word, the sticky error flags and the pair count.
module tb_jtag_axis_sequencer;

    localparam int C_TO = 64;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] S_AXIS_TDATA = '0;
    logic        S_AXIS_TVALID = 1'b0;
    logic        S_AXIS_TREADY;
    logic        S_AXIS_TLAST = 1'b0;
    logic [31:0] M_AXIS_TDATA;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TREADY = 1'b1;
    logic        M_AXIS_TLAST;
    logic        JTAG_ENABLE;
    logic        JTAG_DONE = 1'b0;
    logic [31:0] JTAG_TMS_VECTOR;
    logic [31:0] JTAG_TDI_VECTOR;
    logic [31:0] JTAG_TDO_VECTOR = '0;
    logic        BUSY;
    logic [31:0] PAIR_COUNT;
    logic        TIMEOUT_ERR;
    logic        PROTO_ERR;

    always #5 CLK = ~CLK;

    jtag_axis_sequencer #(
        .C_DONE_TIMEOUT (C_TO),
        .C_TIMEOUT_WIDTH(16)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .S_AXIS_TDATA   (S_AXIS_TDATA),
        .S_AXIS_TVALID  (S_AXIS_TVALID),
        .S_AXIS_TREADY  (S_AXIS_TREADY),
        .S_AXIS_TLAST   (S_AXIS_TLAST),
        .M_AXIS_TDATA   (M_AXIS_TDATA),
        .M_AXIS_TVALID  (M_AXIS_TVALID),
        .M_AXIS_TREADY  (M_AXIS_TREADY),
        .M_AXIS_TLAST   (M_AXIS_TLAST),
        .JTAG_ENABLE    (JTAG_ENABLE),
        .JTAG_DONE      (JTAG_DONE),
        .JTAG_TMS_VECTOR(JTAG_TMS_VECTOR),
        .JTAG_TDI_VECTOR(JTAG_TDI_VECTOR),
        .JTAG_TDO_VECTOR(JTAG_TDO_VECTOR),
        .BUSY           (BUSY),
        .PAIR_COUNT     (PAIR_COUNT),
        .TIMEOUT_ERR    (TIMEOUT_ERR),
        .PROTO_ERR      (PROTO_ERR)
    );

    // One stimulus row: an optional bad TMS word, a pair, engine delay (0 = never), output stall.
    typedef struct {
        logic        bad_tms;
        logic [31:0] tms;
        logic [31:0] tdi;
        logic        last;
        int          delay;
        int          stall;
        logic [31:0] exp_tdo;
        logic        exp_to;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        to;
    } out_t;

    vec_t        tbl[11];
    out_t        exp_q[$];

    int          vectors = 0;
    int          miscompares = 0;
    int          cycle = 0;

    // Scoreboard state
    logic        half = 1'b0;
    logic [31:0] pend_tms = '0;
    logic [31:0] pend_tdi = '0;
    logic        proto_exp = 1'b0;
    logic        to_exp = 1'b0;
    logic [31:0] pair_exp = '0;
    int          tdi_cycle = 0;
    logic [31:0] cur_exp_tdo = '0;
    logic        cur_exp_to = 1'b0;

    // Engine model state
    int          eng_delay = 8;
    logic        eng_busy = 1'b0;
    int          eng_cnt = 0;
    logic [31:0] eng_tdo = '0;
    logic        en_prev = 1'b0;
    logic        mv_prev = 1'b0;
    int          exp_rise = 0;
    logic        pc_pending = 1'b0;
    logic        s_acc = 1'b0;
    logic        m_acc = 1'b0;

    function automatic logic [31:0] ref_tdo(logic [31:0] tdi, int delay);
        return (delay >= 1 && delay <= C_TO) ? tdi : 32'hFFFF_FFFF;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // One clock: score the handshakes about to happen, take the edge, then run the engine model.
    task automatic step();
        out_t o;
        if (!RESET) begin
            if (S_AXIS_TVALID && S_AXIS_TREADY) begin
                if (!half) begin
                    if (S_AXIS_TLAST) proto_exp = 1'b1;
                    else begin
                        pend_tms = S_AXIS_TDATA;
                        half     = 1'b1;
                    end
                end else begin
                    pend_tdi  = S_AXIS_TDATA;
                    half      = 1'b0;
                    o.data    = cur_exp_tdo;
                    o.last    = S_AXIS_TLAST;
                    o.to      = cur_exp_to;
                    exp_q.push_back(o);
                    tdi_cycle = cycle;
                end
                s_acc = 1'b1;
            end
            if (M_AXIS_TVALID) begin
                check("s_tready while output pending", {31'd0, S_AXIS_TREADY}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("output valid with no pair outstanding", {31'd0, M_AXIS_TVALID}, 32'd0);
                end else begin
                    check("m_tdata", M_AXIS_TDATA, exp_q[0].data);
                    check("m_tlast", {31'd0, M_AXIS_TLAST}, {31'd0, exp_q[0].last});
                    if (M_AXIS_TREADY) begin
                        void'(exp_q.pop_front());
                        pair_exp   = pair_exp + 32'd1;
                        pc_pending = 1'b1;
                        m_acc      = 1'b1;
                    end
                end
            end
        end

        @(posedge CLK);
        #1;
        cycle++;

        if (RESET) eng_busy = 1'b0;
        JTAG_DONE       = 1'b0;
        JTAG_TDO_VECTOR = $urandom;
        if (eng_busy) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                JTAG_DONE       = 1'b1;
                JTAG_TDO_VECTOR = eng_tdo;
                eng_busy        = 1'b0;
            end
        end
        if (en_prev) check("enable pulse width", {31'd0, JTAG_ENABLE}, 32'd0);
        if (JTAG_ENABLE && !en_prev) begin
            check("enable latency", cycle, tdi_cycle + 1);
            check("tms vector", JTAG_TMS_VECTOR, pend_tms);
            check("tdi vector", JTAG_TDI_VECTOR, pend_tdi);
            eng_busy = (eng_delay != 0);
            eng_cnt  = eng_delay;
            eng_tdo  = JTAG_TDI_VECTOR;
            exp_rise = cycle + ((eng_delay == 0 || eng_delay > C_TO) ? C_TO : eng_delay) + 1;
        end
        en_prev = JTAG_ENABLE;
        if (M_AXIS_TVALID && !mv_prev && exp_q.size() != 0) begin
            check("tvalid latency", cycle, exp_rise);
            to_exp = to_exp | exp_q[0].to;
            check("timeout_err at output", {31'd0, TIMEOUT_ERR}, {31'd0, to_exp});
        end
        mv_prev = M_AXIS_TVALID;
        if (pc_pending) begin
            check("pair count", PAIR_COUNT, pair_exp);
            pc_pending = 1'b0;
        end
    endtask

    task automatic push_word(logic [31:0] d, logic l);
        S_AXIS_TDATA  = d;
        S_AXIS_TLAST  = l;
        S_AXIS_TVALID = 1'b1;
        s_acc = 1'b0;
        for (int i = 0; i < 400 && !s_acc; i++) step();
        check("slave word accepted", {31'd0, s_acc}, 32'd1);
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TDATA  = $urandom;
        S_AXIS_TLAST  = 1'($urandom);
    endtask

    task automatic wait_out(int stall);
        M_AXIS_TREADY = (stall == 0);
        m_acc = 1'b0;
        for (int i = 0; i < 300 && !M_AXIS_TVALID; i++) step();
        check("output valid raised", {31'd0, M_AXIS_TVALID}, 32'd1);
        for (int i = 0; i < stall; i++) step();
        M_AXIS_TREADY = 1'b1;
        for (int i = 0; i < 5 && !m_acc; i++) step();
        check("output word accepted", {31'd0, m_acc}, 32'd1);
        check("busy after pair", {31'd0, BUSY}, 32'd0);
        check("m_tvalid after pair", {31'd0, M_AXIS_TVALID}, 32'd0);
    endtask

    task automatic send_row(vec_t v, int gap);
        cur_exp_tdo = v.exp_tdo;
        cur_exp_to  = v.exp_to;
        eng_delay   = v.delay;
        if (v.bad_tms) begin
            push_word(32'hBAD0_0000 ^ v.tms, 1'b1);
            check("proto_err after bad tms", {31'd0, PROTO_ERR}, {31'd0, proto_exp});
        end
        push_word(v.tms, 1'b0);
        for (int i = 0; i < gap; i++) step();
        push_word(v.tdi, v.last);
        wait_out(v.stall);
        check("pair count after row", PAIR_COUNT, pair_exp);
        check("proto_err after row", {31'd0, PROTO_ERR}, {31'd0, proto_exp});
        check("timeout_err after row", {31'd0, TIMEOUT_ERR}, {31'd0, to_exp});
    endtask

    task automatic model_reset();
        exp_q.delete();
        half       = 1'b0;
        proto_exp  = 1'b0;
        to_exp     = 1'b0;
        pair_exp   = '0;
        pc_pending = 1'b0;
    endtask

    task automatic check_reset_state();
        check("rst s_tready", {31'd0, S_AXIS_TREADY}, 32'd0);
        check("rst m_tvalid", {31'd0, M_AXIS_TVALID}, 32'd0);
        check("rst m_tdata", M_AXIS_TDATA, 32'd0);
        check("rst m_tlast", {31'd0, M_AXIS_TLAST}, 32'd0);
        check("rst enable", {31'd0, JTAG_ENABLE}, 32'd0);
        check("rst tms vector", JTAG_TMS_VECTOR, 32'd0);
        check("rst tdi vector", JTAG_TDI_VECTOR, 32'd0);
        check("rst busy", {31'd0, BUSY}, 32'd0);
        check("rst pair count", PAIR_COUNT, 32'd0);
        check("rst timeout_err", {31'd0, TIMEOUT_ERR}, 32'd0);
        check("rst proto_err", {31'd0, PROTO_ERR}, 32'd0);
    endtask

    task automatic apply_reset(int n);
        RESET         = 1'b1;
        S_AXIS_TVALID = 1'b0;
        for (int i = 0; i < n; i++) step();
        model_reset();
        check_reset_state();
        RESET = 1'b0;
        step();
        check("s_tready after reset", {31'd0, S_AXIS_TREADY}, 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   r;

        tbl[0]  = '{1'b0, 32'h0000_001F, 32'hA5A5_A5A5, 1'b1, 8,  0,  32'hA5A5_A5A5, 1'b0};
        tbl[1]  = '{1'b0, 32'h0000_0003, 32'h1111_1111, 1'b0, 8,  0,  32'h1111_1111, 1'b0};
        tbl[2]  = '{1'b0, 32'h0000_0007, 32'h2222_2222, 1'b0, 12, 10, 32'h2222_2222, 1'b0};
        tbl[3]  = '{1'b0, 32'h0000_000F, 32'h3333_3333, 1'b0, 5,  0,  32'h3333_3333, 1'b0};
        tbl[4]  = '{1'b0, 32'h0000_0001, 32'h4444_4444, 1'b1, 8,  0,  32'h4444_4444, 1'b0};
        tbl[5]  = '{1'b1, 32'h0000_000C, 32'h5A5A_0F0F, 1'b1, 3,  0,  32'h5A5A_0F0F, 1'b0};
        tbl[6]  = '{1'b0, 32'h0000_001F, 32'hC0DE_0064, 1'b0, 64, 0,  32'hC0DE_0064, 1'b0};
        tbl[7]  = '{1'b0, 32'h0000_001F, 32'h1234_5678, 1'b1, 0,  0,  32'hFFFF_FFFF, 1'b1};
        tbl[8]  = '{1'b0, 32'h0000_0003, 32'h8765_4321, 1'b1, 10, 2,  32'h8765_4321, 1'b0};
        tbl[9]  = '{1'b0, 32'h0000_0000, 32'h0F0F_F0F0, 1'b0, 1,  0,  32'h0F0F_F0F0, 1'b0};
        tbl[10] = '{1'b0, 32'h0000_0006, 32'hDEAD_BEEF, 1'b1, 65, 0,  32'hFFFF_FFFF, 1'b1};

        apply_reset(3);

        foreach (tbl[i]) send_row(tbl[i], 0);

        // DONE while idle must be ignored.
        JTAG_DONE       = 1'b1;
        JTAG_TDO_VECTOR = 32'h5555_AAAA;
        for (int i = 0; i < 4; i++) step();
        check("spurious done: busy", {31'd0, BUSY}, 32'd0);
        check("spurious done: pair count", PAIR_COUNT, pair_exp);

        // Reset while waiting for DONE, then a clean pair.
        cur_exp_tdo = 32'hFFFF_FFFF;
        cur_exp_to  = 1'b1;
        eng_delay   = 0;
        push_word(32'h0000_0011, 1'b0);
        push_word(32'h7777_7777, 1'b1);
        for (int i = 0; i < 10; i++) step();
        check("busy in wait_done", {31'd0, BUSY}, 32'd1);
        apply_reset(2);
        v = '{1'b0, 32'h0000_0013, 32'h6C6C_3939, 1'b1, 6, 0, 32'h6C6C_3939, 1'b0};
        send_row(v, 1);

        // Reset while an output word is stalled: it must vanish.
        cur_exp_tdo   = 32'h0BAD_F00D;
        cur_exp_to    = 1'b0;
        eng_delay     = 5;
        M_AXIS_TREADY = 1'b0;
        push_word(32'h0000_0002, 1'b0);
        push_word(32'h0BAD_F00D, 1'b0);
        for (int i = 0; i < 50 && !M_AXIS_TVALID; i++) step();
        check("stalled output present", {31'd0, M_AXIS_TVALID}, 32'd1);
        RESET = 1'b1;
        step();
        check("m_tvalid dropped by reset", {31'd0, M_AXIS_TVALID}, 32'd0);
        apply_reset(1);
        M_AXIS_TREADY = 1'b1;
        v = '{1'b0, 32'h0000_0009, 32'h1357_9BDF, 1'b0, 4, 1, 32'h1357_9BDF, 1'b0};
        send_row(v, 0);

        // Randomised pairs against the scoreboard.
        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 9));
            v.bad_tms = ($urandom_range(0, 9) == 0);
            v.tms     = $urandom;
            v.tdi     = $urandom;
            v.last    = 1'($urandom);
            if (r == 0)      v.delay = 0;
            else if (r == 1) v.delay = C_TO;
            else if (r == 2) v.delay = C_TO + int'($urandom_range(1, 3));
            else             v.delay = int'($urandom_range(1, 40));
            v.stall   = int'($urandom_range(0, 3));
            v.exp_tdo = ref_tdo(v.tdi, v.delay);
            v.exp_to  = (v.delay == 0 || v.delay > C_TO);
            send_row(v, int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
